// File: rtl/reg_file_sb.sv
// Parametrised multi-read-port register file with write-to-read bypass
// and a per-register pending-write scoreboard for RAW hazard detection.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       busy_set,
    input  logic [ADDR_W-1:0]          busy_addr,
    output logic                       any_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  sb_q;
    logic [DEPTH-1:0]  sb_d;

    logic wr_en;
    logic set_en;

    // Register 0 is never a target, and nothing lands while in reset
    assign wr_en  = we && !rst && (waddr != '0);
    assign set_en = busy_set && !rst && (busy_addr != '0);

    // Next-state: data write plus scoreboard with set taking priority
    always_comb begin
        regs_d = regs_q;
        sb_d   = sb_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
        for (int r = 1; r < DEPTH; r++) begin
            if (set_en && (busy_addr == ADDR_W'(r))) begin
                sb_d[r] = 1'b1;
            end else if (wr_en && (waddr == ADDR_W'(r))) begin
                sb_d[r] = 1'b0;
            end
        end
        sb_d[0] = 1'b0;
    end

    // State registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            sb_q   <= '0;
        end else begin
            regs_q <= regs_d;
            sb_q   <= sb_d;
        end
    end

    // Independent combinational read ports with optional forwarding
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra  = raddr[i*ADDR_W +: ADDR_W];
        assign hit = BYPASS && wr_en && (waddr == ra);

        // Forwarded data is final, so a hit also hides the pending bit
        always_comb begin
            rdata[i*DATA_W +: DATA_W] = '0;
            rbusy[i]                  = 1'b0;
            if (!rst) begin
                rdata[i*DATA_W +: DATA_W] = hit ? wdata : regs_q[ra];
                rbusy[i]                  = sb_q[ra] && !hit;
            end
        end
    end

    // Drain status reflects registered scoreboard only
    assign any_busy = !rst && (|sb_q);

endmodule
